// File: rtl/prog_seq_ctrl_pkg.sv
// Shared types and constants for the instruction sequencer.
// Holds the FSM state encoding and the saturating cycle-counter helper.
package prog_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    EXEC    = 3'd2,
    MEMWAIT = 3'd3,
    DONE    = 3'd4,
    FAULT   = 3'd5
  } seq_state_t;

  localparam int PC_W_DEF  = 12;
  localparam int LUT_DEPTH = 4;
  localparam int TMO_W     = 4;
  localparam int CYC_W     = 16;

  function automatic logic [CYC_W-1:0] sat_inc_cyc(input logic [CYC_W-1:0] v);
    return (v == {CYC_W{1'b1}}) ? v : v + {{(CYC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/prog_seq_ctrl_target_lut.sv
// Read-only jump/branch target table: purely combinational lookup of a
// parameter-initialised table indexed by the decoder's target select.
module target_lut
  import prog_seq_pkg::*;
#(
  parameter int                          PC_W     = PC_W_DEF,
  parameter logic [LUT_DEPTH*PC_W-1:0]   LUT_INIT = '0
) (
  input  logic [1:0]      i_sel,
  output logic [PC_W-1:0] o_target
);

  logic [PC_W-1:0] w_tab [LUT_DEPTH];

  for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_tab
    assign w_tab[g] = LUT_INIT[g*PC_W +: PC_W];
  end

  assign o_target = w_tab[i_sel];

endmodule

// File: rtl/prog_seq_ctrl.sv
// Program sequencer for the 9-bit core: owns the PC, steps FETCH/EXEC,
// stalls on data-memory accesses with a timeout, and gates write commits.
module prog_seq_ctrl
  import prog_seq_pkg::*;
#(
  parameter int                         PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0]            START_ADDR = '0,
  parameter int unsigned                MEM_TMO    = 15,
  parameter logic [LUT_DEPTH*PC_W-1:0]  LUT_INIT   = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             CtrlJump,
  input  logic             CtrlBranch,
  input  logic             CtrlLoad,
  input  logic             CtrlStore,
  input  logic             CtrlRegWr,
  input  logic             CtrlMemWr,
  input  logic             CtrlHalt,
  input  logic [1:0]       TargSel,
  input  logic             BranchCond,
  input  logic             MemReady,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             RegWrCommit,
  output logic             MemWrCommit,
  output logic             MemReq,
  output logic             Busy,
  output logic             Done,
  output logic             Fault,
  output logic [CYC_W-1:0] CycleCnt
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);
  localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};

  seq_state_t       r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt;
  logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
  logic [CYC_W-1:0] r_cyc, w_cyc_nxt;
  logic [PC_W-1:0]  w_target;
  logic             w_memop;
  logic             w_busy;
  logic             w_regwr_commit;
  logic             w_memwr_commit;

  target_lut #(
    .PC_W     (PC_W),
    .LUT_INIT (LUT_INIT)
  ) u_target_lut (
    .i_sel    (TargSel),
    .o_target (w_target)
  );

  assign w_memop = CtrlLoad | CtrlStore | CtrlMemWr;
  assign w_busy  = (r_state == FETCH) || (r_state == EXEC) || (r_state == MEMWAIT);

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_tmo_nxt      = r_tmo;
    w_cyc_nxt      = w_busy ? sat_inc_cyc(r_cyc) : r_cyc;
    w_regwr_commit = 1'b0;
    w_memwr_commit = 1'b0;

    case (r_state)
      IDLE, DONE, FAULT: begin
        if (Start) begin
          w_state_nxt = FETCH;
          w_pc_nxt    = START_ADDR;
          w_cyc_nxt   = '0;
        end
      end
      FETCH: w_state_nxt = EXEC;
      EXEC: begin
        // Halt beats memory ops, which beat jump, which beats branch.
        if (CtrlHalt) begin
          w_state_nxt = DONE;
        end else if (w_memop) begin
          w_state_nxt = MEMWAIT;
          w_tmo_nxt   = '0;
        end else if (CtrlJump) begin
          w_pc_nxt       = w_target;
          w_regwr_commit = CtrlRegWr;
          w_state_nxt    = FETCH;
        end else if (CtrlBranch) begin
          w_pc_nxt    = BranchCond ? (r_pc + w_target) : (r_pc + PC_ONE);
          w_state_nxt = FETCH;
        end else begin
          w_pc_nxt       = r_pc + PC_ONE;
          w_regwr_commit = CtrlRegWr;
          w_state_nxt    = FETCH;
        end
      end
      MEMWAIT: begin
        if (MemReady) begin
          w_regwr_commit = CtrlLoad & CtrlRegWr;
          w_memwr_commit = CtrlMemWr | CtrlStore;
          w_pc_nxt       = r_pc + PC_ONE;
          w_state_nxt    = FETCH;
        end else begin
          w_tmo_nxt = r_tmo + {{(TMO_W-1){1'b0}}, 1'b1};
          if (r_tmo == TMO_LAST) w_state_nxt = FAULT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_pc    <= START_ADDR;
      r_tmo   <= '0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tmo   <= w_tmo_nxt;
      r_cyc   <= w_cyc_nxt;
    end
  end

  assign ProgCtr     = r_pc;
  assign CycleCnt    = r_cyc;
  assign RegWrCommit = w_regwr_commit;
  assign MemWrCommit = w_memwr_commit;
  assign MemReq      = (r_state == MEMWAIT);
  assign Busy        = w_busy;
  assign Done        = (r_state == DONE);
  assign Fault       = (r_state == FAULT);

endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Bench for prog_seq_ctrl: directed scenarios plus randomized instruction
// streams checked against an instruction-level model of PC, commits and cycles.
module tb_prog_seq_ctrl;

  localparam int PC_W = 12;
  localparam logic [4*PC_W-1:0] LUT = {12'hFFF, 12'h123, 12'h040, 12'h000};

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        CtrlJump = 1'b0, CtrlBranch = 1'b0, CtrlLoad = 1'b0, CtrlStore = 1'b0;
  logic        CtrlRegWr = 1'b0, CtrlMemWr = 1'b0, CtrlHalt = 1'b0;
  logic [1:0]  TargSel = 2'd0;
  logic        BranchCond = 1'b0, MemReady = 1'b0;
  logic [11:0] ProgCtr;
  logic        RegWrCommit, MemWrCommit, MemReq, Busy, Done, Fault;
  logic [15:0] CycleCnt;

  always #5 Clk = ~Clk;

  prog_seq_ctrl #(
    .PC_W(PC_W), .START_ADDR(12'h000), .MEM_TMO(15), .LUT_INIT(LUT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .CtrlJump(CtrlJump), .CtrlBranch(CtrlBranch), .CtrlLoad(CtrlLoad),
    .CtrlStore(CtrlStore), .CtrlRegWr(CtrlRegWr), .CtrlMemWr(CtrlMemWr),
    .CtrlHalt(CtrlHalt), .TargSel(TargSel), .BranchCond(BranchCond),
    .MemReady(MemReady), .ProgCtr(ProgCtr), .RegWrCommit(RegWrCommit),
    .MemWrCommit(MemWrCommit), .MemReq(MemReq), .Busy(Busy), .Done(Done),
    .Fault(Fault), .CycleCnt(CycleCnt)
  );

  typedef struct {
    logic halt, load, store, memwr, jump, branch, regwr, cond;
    logic [1:0] sel;
    int wait_n;
  } ins_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] m_pc;
  logic [15:0] m_cc;
  bit          start_noise = 1'b0;
  logic [11:0] lut_m [4] = '{12'h000, 12'h040, 12'h123, 12'hFFF};

  function automatic logic [5:0] flags();
    return {Busy, Done, Fault, MemReq, RegWrCommit, MemWrCommit};
  endfunction

  function automatic logic [15:0] cc_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_ctrl();
    CtrlJump = 0; CtrlBranch = 0; CtrlLoad = 0; CtrlStore = 0;
    CtrlRegWr = 0; CtrlMemWr = 0; CtrlHalt = 0; TargSel = 0; BranchCond = 0;
  endtask

  task automatic do_start();
    Start = 1'b1;
    step();
    Start = 1'b0;
    m_pc = 12'h000;
    m_cc = 16'd0;
  endtask

  function automatic ins_t blank();
    ins_t i;
    i = '{halt:0, load:0, store:0, memwr:0, jump:0, branch:0, regwr:0, cond:0, sel:0, wait_n:0};
    return i;
  endfunction

  // Runs one instruction from its FETCH cycle; outc: 0 back in FETCH, 1 DONE, 2 FAULT.
  task automatic run_instr(input ins_t ins, input string tag, output int outc);
    logic memop, exp_rw, rdy;
    logic [33:0] obs, exp;
    memop = ins.load | ins.store | ins.memwr;
    outc = 0;
    clr_ctrl();
    CtrlRegWr = 1; CtrlMemWr = 1; MemReady = 1;
    Start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    obs = {flags(), ProgCtr, CycleCnt}; exp = {6'b100000, m_pc, m_cc};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL %s fetch got=%h exp=%h", tag, obs, exp); end
    step(); m_cc = cc_inc(m_cc);

    CtrlHalt = ins.halt; CtrlLoad = ins.load; CtrlStore = ins.store; CtrlMemWr = ins.memwr;
    CtrlJump = ins.jump; CtrlBranch = ins.branch; CtrlRegWr = ins.regwr;
    TargSel = ins.sel; BranchCond = ins.cond; MemReady = 1;
    Start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    exp_rw = ins.halt ? 1'b0 : memop ? 1'b0 : ins.jump ? ins.regwr : ins.branch ? 1'b0 : ins.regwr;
    obs = {flags(), ProgCtr, CycleCnt}; exp = {4'b1000, exp_rw, 1'b0, m_pc, m_cc};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL %s exec got=%h exp=%h", tag, obs, exp); end
    step(); m_cc = cc_inc(m_cc);

    if (ins.halt) begin
      Start = 0; #1;
      obs = {flags(), ProgCtr, CycleCnt}; exp = {6'b010000, m_pc, m_cc};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL %s halt got=%h exp=%h", tag, obs, exp); end
      outc = 1;
    end else if (memop) begin
      rdy = 1'b0;
      for (int k = 1; k <= 15; k++) begin
        rdy = (k == ins.wait_n + 1);
        MemReady = rdy;
        Start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        obs = {flags(), ProgCtr, CycleCnt};
        exp = {4'b1001, rdy & ins.load & ins.regwr, rdy & (ins.memwr | ins.store), m_pc, m_cc};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL %s memwait%0d got=%h exp=%h", tag, k, obs, exp); end
        step(); m_cc = cc_inc(m_cc);
        if (rdy) break;
      end
      if (rdy) m_pc = m_pc + 12'd1;
      else begin
        Start = 0; MemReady = 1; #1;
        obs = {flags(), ProgCtr, CycleCnt}; exp = {6'b001000, m_pc, m_cc};
        n_checks++;
        if (obs !== exp) begin n_fail++; $display("FAIL %s fault got=%h exp=%h", tag, obs, exp); end
        outc = 2;
      end
    end else begin
      if (ins.jump) m_pc = lut_m[ins.sel];
      else if (ins.branch && ins.cond) m_pc = m_pc + lut_m[ins.sel];
      else m_pc = m_pc + 12'd1;
    end
  endtask

  task automatic test_reset();
    logic [33:0] obs;
    Reset = 0; Start = 1; CtrlRegWr = 1; CtrlLoad = 1; MemReady = 1;
    repeat (2) @(posedge Clk);
    #1;
    obs = {flags(), ProgCtr, CycleCnt};
    n_checks++;
    if (obs !== 34'd0) begin n_fail++; $display("FAIL reset_state got=%h exp=0", obs); end
    Reset = 1; Start = 0; clr_ctrl();
    step();
    obs = {flags(), ProgCtr, CycleCnt};
    n_checks++;
    if (obs !== 34'd0) begin n_fail++; $display("FAIL idle_no_start got=%h exp=0", obs); end
    do_start();
  endtask

  task automatic test_sequential();
    ins_t i; int o;
    i = blank(); i.regwr = 1;
    for (int n = 0; n < 3; n++) run_instr(i, "seq", o);
    n_checks++;
    if (m_pc !== 12'h003 || ProgCtr !== 12'h003) begin
      n_fail++; $display("FAIL seq_pc got=%h exp=003", ProgCtr);
    end
  endtask

  task automatic test_jump_branch();
    ins_t i; int o;
    i = blank(); i.jump = 1; i.sel = 2'd1; i.regwr = 1;
    run_instr(i, "jump", o);
    i = blank(); i.branch = 1; i.sel = 2'd1; i.cond = 1; i.regwr = 1;
    run_instr(i, "br_taken", o);
    n_checks++;
    if (ProgCtr !== 12'h080) begin n_fail++; $display("FAIL br_taken_pc got=%h exp=080", ProgCtr); end
    i = blank(); i.jump = 1; i.sel = 2'd1;
    run_instr(i, "jump2", o);
    i = blank(); i.branch = 1; i.sel = 2'd1; i.cond = 0;
    run_instr(i, "br_not", o);
    n_checks++;
    if (ProgCtr !== 12'h041) begin n_fail++; $display("FAIL br_not_pc got=%h exp=041", ProgCtr); end
  endtask

  task automatic test_load_stall();
    ins_t i; int o;
    i = blank(); i.load = 1; i.regwr = 1; i.wait_n = 3;
    run_instr(i, "load3", o);
    i = blank(); i.store = 1; i.regwr = 1; i.wait_n = 0;
    run_instr(i, "store0", o);
    i = blank(); i.memwr = 1; i.jump = 1; i.sel = 2'd3; i.wait_n = 1;
    run_instr(i, "memwr_over_jump", o);
  endtask

  task automatic test_wrap();
    ins_t i; int o;
    i = blank(); i.jump = 1; i.sel = 2'd3;
    run_instr(i, "jump_fff", o);
    i = blank(); i.regwr = 1;
    run_instr(i, "seq_wrap", o);
    n_checks++;
    if (ProgCtr !== 12'h000) begin n_fail++; $display("FAIL pc_wrap got=%h exp=000", ProgCtr); end
    i = blank(); i.branch = 1; i.cond = 1; i.sel = 2'd3;
    run_instr(i, "br_fff", o);
    i = blank(); i.branch = 1; i.cond = 1; i.sel = 2'd1;
    run_instr(i, "br_wrap", o);
    n_checks++;
    if (ProgCtr !== 12'h03F) begin n_fail++; $display("FAIL br_wrap_pc got=%h exp=03f", ProgCtr); end
  endtask

  task automatic test_random();
    ins_t i; int o;
    start_noise = 1'b1;
    for (int n = 0; n < 60; n++) begin
      i = blank();
      i.load   = ($urandom_range(0, 5) == 0);
      i.store  = ($urandom_range(0, 5) == 0);
      i.memwr  = ($urandom_range(0, 5) == 0);
      i.jump   = ($urandom_range(0, 2) == 0);
      i.branch = 1'($urandom_range(0, 1));
      i.regwr  = 1'($urandom_range(0, 1));
      i.cond   = 1'($urandom_range(0, 1));
      i.sel    = 2'($urandom_range(0, 3));
      i.wait_n = $urandom_range(0, 4);
      run_instr(i, "rand", o);
    end
    start_noise = 1'b0;
  endtask

  task automatic test_timeout();
    ins_t i; int o;
    logic [33:0] obs, exp;
    i = blank(); i.store = 1; i.wait_n = 14;
    run_instr(i, "store_last_cycle", o);
    n_checks++;
    if (o !== 0) begin n_fail++; $display("FAIL ready_on_tmo got=%0d exp=0", o); end
    i = blank(); i.store = 1; i.memwr = 1; i.wait_n = 99;
    run_instr(i, "store_tmo", o);
    n_checks++;
    if (o !== 2) begin n_fail++; $display("FAIL tmo_outcome got=%0d exp=2", o); end
    clr_ctrl(); CtrlStore = 1; MemReady = 1;
    repeat (2) step();
    obs = {flags(), ProgCtr, CycleCnt}; exp = {6'b001000, m_pc, m_cc};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL fault_hold got=%h exp=%h", obs, exp); end
    do_start();
    i = blank(); i.regwr = 1;
    run_instr(i, "restart_fault", o);
  endtask

  task automatic test_halt();
    ins_t i; int o;
    logic [33:0] obs, exp;
    i = blank(); i.regwr = 1;
    run_instr(i, "pre_halt", o);
    i = blank(); i.halt = 1; i.load = 1; i.jump = 1; i.regwr = 1; i.memwr = 1;
    run_instr(i, "halt", o);
    n_checks++;
    if (o !== 1) begin n_fail++; $display("FAIL halt_outcome got=%0d exp=1", o); end
    for (int n = 0; n < 3; n++) begin
      CtrlJump = 1'($urandom_range(0, 1)); CtrlRegWr = 1; MemReady = 1'($urandom_range(0, 1));
      step();
    end
    obs = {flags(), ProgCtr, CycleCnt}; exp = {6'b010000, m_pc, m_cc};
    n_checks++;
    if (obs !== exp) begin n_fail++; $display("FAIL done_hold got=%h exp=%h", obs, exp); end
    do_start();
    i = blank(); i.regwr = 1;
    run_instr(i, "restart_done", o);
  endtask

  task automatic test_async_reset();
    logic [33:0] obs;
    clr_ctrl(); CtrlLoad = 1; CtrlRegWr = 1; MemReady = 0;
    repeat (2) step();
    MemReady = 1; #1;
    n_checks++;
    if ({MemReq, RegWrCommit} !== 2'b11) begin
      n_fail++; $display("FAIL memwait_pre_reset got=%b exp=11", {MemReq, RegWrCommit});
    end
    Reset = 0; #1;
    obs = {flags(), ProgCtr, CycleCnt};
    n_checks++;
    if (obs !== 34'd0) begin n_fail++; $display("FAIL async_reset got=%h exp=0", obs); end
    Reset = 1; clr_ctrl(); MemReady = 0;
    step();
    obs = {flags(), ProgCtr, CycleCnt};
    n_checks++;
    if (obs !== 34'd0) begin n_fail++; $display("FAIL post_reset_idle got=%h exp=0", obs); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_jump_branch();
    test_load_stall();
    test_wrap();
    test_random();
    test_timeout();
    test_halt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
